// File: rtl/alt_vipvfr131_raster_seq_pkg.sv
// Shared state encoding and default widths for the raster sequencer.
// RASTER_SEQ_LINE_GAP_EN adds the default width of the per-line gap counter.
package alt_vipvfr131_raster_seq_pkg;

    localparam int STATE_W               = 2;
    localparam int DEF_WORD_LENGTH       = 12;
    localparam int DEF_TICKS_WORD_LENGTH = 2;
`ifdef RASTER_SEQ_LINE_GAP_EN
    localparam int DEF_GAP_WIDTH         = 8;
`endif

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alt_vipvfr131_raster_seq_if.sv
// Command, beat and status signals between the sequencer (slave) and its user (master).
// RASTER_SEQ_LINE_GAP_EN adds the cmd_gap field and the GAP_WIDTH parameter.
interface alt_vipvfr131_raster_seq_if
    import alt_vipvfr131_raster_seq_pkg::*;
#(
    parameter int WORD_LENGTH       = DEF_WORD_LENGTH,
    parameter int TICKS_WORD_LENGTH = DEF_TICKS_WORD_LENGTH
`ifdef RASTER_SEQ_LINE_GAP_EN
    ,
    parameter int GAP_WIDTH         = DEF_GAP_WIDTH
`endif
) ();

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [WORD_LENGTH-1:0]       cmd_width;
    logic [WORD_LENGTH-1:0]       cmd_height;
    logic [TICKS_WORD_LENGTH-1:0] cmd_planes;
`ifdef RASTER_SEQ_LINE_GAP_EN
    logic [GAP_WIDTH-1:0]         cmd_gap;
`endif
    logic                         stop;
    logic                         out_valid;
    logic                         out_ready;
    logic [WORD_LENGTH-1:0]       out_x;
    logic [WORD_LENGTH-1:0]       out_y;
    logic [TICKS_WORD_LENGTH-1:0] out_plane;
    logic                         out_sop;
    logic                         out_eol;
    logic                         out_eop;
    logic                         busy;
    logic                         frame_done;
    logic                         frame_aborted;

    modport master (
        output cmd_valid, cmd_width, cmd_height, cmd_planes,
`ifdef RASTER_SEQ_LINE_GAP_EN
        output cmd_gap,
`endif
        output stop, out_ready,
        input  cmd_ready, out_valid, out_x, out_y, out_plane,
        input  out_sop, out_eol, out_eop, busy, frame_done, frame_aborted
    );

    modport slave (
        input  cmd_valid, cmd_width, cmd_height, cmd_planes,
`ifdef RASTER_SEQ_LINE_GAP_EN
        input  cmd_gap,
`endif
        input  stop, out_ready,
        output cmd_ready, out_valid, out_x, out_y, out_plane,
        output out_sop, out_eol, out_eop, busy, frame_done, frame_aborted
    );

endinterface

// File: rtl/alt_vipvfr131_raster_axis_count.sv
// One raster axis counter: counts 0..limit and reports when it sits at its limit.
module alt_vipvfr131_raster_axis_count #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Clear wins over enable so a fresh command always starts from zero.
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (enable) begin
            value_d = wrap ? '0 : value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign wrap  = (value_q == limit);
    assign value = value_q;

endmodule

// File: rtl/alt_vipvfr131_raster_sequencer.sv
// Frame-level raster sequencer: steps plane/x/y counters under a ready/valid beat handshake.
// RASTER_SEQ_LINE_GAP_EN enables the GAP state that idles cmd_gap cycles after each line.
module alt_vipvfr131_raster_sequencer
    import alt_vipvfr131_raster_seq_pkg::*;
#(
    parameter int WORD_LENGTH       = DEF_WORD_LENGTH,
    parameter int TICKS_WORD_LENGTH = DEF_TICKS_WORD_LENGTH
`ifdef RASTER_SEQ_LINE_GAP_EN
    ,
    parameter int GAP_WIDTH         = DEF_GAP_WIDTH
`endif
) (
    input logic                      clk,
    input logic                      reset,
    alt_vipvfr131_raster_seq_if.slave bus
);

    localparam logic [STATE_W-1:0] S_IDLE = ST_IDLE;
    localparam logic [STATE_W-1:0] S_RUN  = ST_RUN;
    localparam logic [STATE_W-1:0] S_DONE = ST_DONE;
`ifdef RASTER_SEQ_LINE_GAP_EN
    localparam logic [STATE_W-1:0] S_GAP  = ST_GAP;
`endif

    logic [STATE_W-1:0]           state_q, state_d;
    logic                         aborted_q, aborted_d;
    logic [WORD_LENGTH-1:0]       width_q, height_q;
    logic [TICKS_WORD_LENGTH-1:0] planes_q;
`ifdef RASTER_SEQ_LINE_GAP_EN
    logic [GAP_WIDTH-1:0]         gap_q;
    logic [GAP_WIDTH-1:0]         gapCnt_q, gapCnt_d;
`endif

    logic                         cmdAccept, beatAccept;
    logic                         planeWrap, xWrap, yWrap;
    logic                         eolBeat, eopBeat;
    logic [TICKS_WORD_LENGTH-1:0] planeVal;
    logic [WORD_LENGTH-1:0]       xVal, yVal;

    assign cmdAccept  = (state_q == S_IDLE) && bus.cmd_valid;
    assign beatAccept = (state_q == S_RUN) && bus.out_ready;
    assign eolBeat    = planeWrap && xWrap;
    assign eopBeat    = eolBeat && yWrap;

    alt_vipvfr131_raster_axis_count #(.WIDTH(TICKS_WORD_LENGTH)) u_plane (
        .clk(clk), .reset(reset), .enable(beatAccept), .clear(cmdAccept),
        .limit(planes_q), .value(planeVal), .wrap(planeWrap)
    );

    alt_vipvfr131_raster_axis_count #(.WIDTH(WORD_LENGTH)) u_x (
        .clk(clk), .reset(reset), .enable(beatAccept && planeWrap), .clear(cmdAccept),
        .limit(width_q), .value(xVal), .wrap(xWrap)
    );

    alt_vipvfr131_raster_axis_count #(.WIDTH(WORD_LENGTH)) u_y (
        .clk(clk), .reset(reset), .enable(beatAccept && eolBeat), .clear(cmdAccept),
        .limit(height_q), .value(yVal), .wrap(yWrap)
    );

    // stop outranks the eop->DONE step; a beat accepted alongside stop still advances the counters.
    always_comb begin
        state_d   = state_q;
        aborted_d = 1'b0;
`ifdef RASTER_SEQ_LINE_GAP_EN
        gapCnt_d  = gapCnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (beatAccept && eopBeat) begin
                    state_d = S_DONE;
`ifdef RASTER_SEQ_LINE_GAP_EN
                end else if (beatAccept && eolBeat && (gap_q != '0)) begin
                    state_d  = S_GAP;
                    gapCnt_d = gap_q;
`endif
                end
            end
`ifdef RASTER_SEQ_LINE_GAP_EN
            S_GAP: begin
                gapCnt_d = gapCnt_q - GAP_WIDTH'(1);
                if (bus.stop) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (gapCnt_q == GAP_WIDTH'(1)) begin
                    state_d = S_RUN;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            aborted_q <= 1'b0;
            width_q   <= '0;
            height_q  <= '0;
            planes_q  <= '0;
`ifdef RASTER_SEQ_LINE_GAP_EN
            gap_q     <= '0;
            gapCnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            aborted_q <= aborted_d;
`ifdef RASTER_SEQ_LINE_GAP_EN
            gapCnt_q  <= gapCnt_d;
`endif
            if (cmdAccept) begin
                width_q  <= bus.cmd_width;
                height_q <= bus.cmd_height;
                planes_q <= bus.cmd_planes;
`ifdef RASTER_SEQ_LINE_GAP_EN
                gap_q    <= bus.cmd_gap;
`endif
            end
        end
    end

    // Flags are qualified by out_valid so idle limits of zero never look like a frame marker.
    assign bus.cmd_ready     = (state_q == S_IDLE);
    assign bus.out_valid     = (state_q == S_RUN);
    assign bus.out_x         = xVal;
    assign bus.out_y         = yVal;
    assign bus.out_plane     = planeVal;
    assign bus.out_sop       = bus.out_valid && (xVal == '0) && (yVal == '0) && (planeVal == '0);
    assign bus.out_eol       = bus.out_valid && eolBeat;
    assign bus.out_eop       = bus.out_valid && eopBeat;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.frame_done    = (state_q == S_DONE);
    assign bus.frame_aborted = aborted_q;

endmodule

// File: doc/alt_vipvfr131_raster_sequencer.md
# alt_vipvfr131_raster_sequencer

Frame-level controller for the frame reader's raster counters. It accepts one frame command at a time (active width, height, colour planes per pixel), steps nested plane/column/row counters under a ready/valid output handshake, and emits per-beat coordinates and packet markers. Downstream, the memory-read address generator and the colour-plane packer consume these beats.

## Interface
- WORD_LENGTH, 12, width of x/y counters and of cmd_width/cmd_height
- TICKS_WORD_LENGTH, 2, width of plane counter and cmd_planes
- GAP_WIDTH, 8, width of cmd_gap (only with the line-gap macro)
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- cmd_valid  in  1  frame command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_width  in  WORD_LENGTH  active pixels per line minus 1
- cmd_height  in  WORD_LENGTH  active lines minus 1
- cmd_planes  in  TICKS_WORD_LENGTH  colour planes per pixel minus 1
- cmd_gap  in  GAP_WIDTH  idle cycles inserted after each line (macro only)
- stop  in  1  abort current frame
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_x / out_y  out  WORD_LENGTH  column / row of current beat
- out_plane  out  TICKS_WORD_LENGTH  plane index of current beat
- out_sop, out_eol, out_eop  out  1 each  first beat of frame / last beat of line / last beat of frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after eop beat accepted
- frame_aborted  out  1  one-cycle pulse when stop ends a frame

## Operation
- States: IDLE, RUN, GAP (macro only), DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch width/height/planes/gap, zero the x/y/plane counters, go RUN.
- RUN: out_valid=1. A beat is accepted when out_valid&&out_ready. The accepted beat advances the counters in this order: plane innermost, then x, then y outermost.
- Plane wraps to 0 when plane==planes; this carries into x. x wraps to 0 when x==width with plane wrap; this carries into y.
- Counter comparisons are unsigned. The counters never exceed the latched limits.
- out_sop = (x,y,plane)==0.
- out_eol = x==width && plane==planes.
- out_eop = out_eol && y==height.
- Accepted eop beat → DONE. DONE lasts one cycle with frame_done=1, then → IDLE.
- Accepted eol beat that is not eop → GAP if macro enabled and gap≠0, otherwise stay in RUN.
- stop in RUN or GAP: next state IDLE, frame_aborted=1 for one cycle. No frame_done.
- stop in the same cycle as an accepted beat: the beat counts as delivered, but the frame still aborts. stop has priority over the eop→DONE transition.
- stop in IDLE or DONE is ignored.
- Commands arriving outside IDLE are held off (cmd_ready=0).
- Minimum frame (all fields 0): a single beat with sop, eol and eop all high.

## Timing
- Reset: state IDLE, all counters 0. cmd_ready=1. out_valid, busy, frame_done, frame_aborted = 0. All out_* data outputs = 0.
- Command accepted at cycle n → first beat valid at n+1.
- Beat throughput: 1 per cycle while out_ready is held high.
- out_x/y/plane and flags are stable while out_valid && !out_ready.
- Accepted eop at cycle n → frame_done=1 at n+1 → cmd_ready=1 at n+2. Earliest next command is accepted at n+2.
- GAP: out_valid=0 for exactly cmd_gap cycles after the eol beat, then RUN resumes with x=0 and y+1.

## Configuration
- RASTER_SEQ_LINE_GAP_EN defined: the GAP state, the cmd_gap port, GAP_WIDTH and the gap down-counter exist.
- RASTER_SEQ_LINE_GAP_EN undefined: all of the above are removed. Lines are emitted back-to-back, and the transition after an eol beat is always RUN→RUN.

## Structure
- Package alt_vipvfr131_raster_seq_pkg holds:
  - state enum (IDLE, RUN, GAP, DONE)
  - state width constant
  - default widths
- One sub-module, alt_vipvfr131_raster_axis_count, is instantiated three times (plane, x, y).
- Its interface: clk, reset, enable, clear, limit; outputs value and wrap.
- All carry/chaining logic lives in the top module.

## Test plan
- Command width=3, height=1, planes=0, out_ready=1 → 8 beats on consecutive cycles. sop on beat 0, eol on beats 3 and 7, eop on beat 7. frame_done 1 cycle later.
- Width=1, height=0, planes=2 → plane sequence 0,1,2,0,1,2 with x=0,0,0,1,1,1. eol and eop on the last beat only.
- Random out_ready stalls on a 4×3 frame → coordinates held during stalls. No beat is lost or duplicated; all 12 beats arrive in raster order.
- stop asserted on beat 5 of a 4×4 frame, with that beat accepted → frame_aborted pulse, no frame_done, IDLE next cycle. A new command is accepted with sop at (0,0).
- All-zero command → single beat with sop=eol=eop=1. Back-to-back commands → second frame's first beat arrives 3 cycles after the first frame's eop.
- Macro on, gap=2, width=1, height=1 → out_valid low for exactly 2 cycles after the first eol beat. Macro off with the same frame → no bubble.
